mem_port_arbiter: RTL and testbench

// Round-robin arbiter sharing one 32-bit memory port between the core's instruction-fetch and load/store ports.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch
// and load/store, with byte-lane alignment and a WAIT-state timeout.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TMO_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reqI,
   input  logic [ADDR_W-1:0] memIAddr,
   output logic [DATA_W-1:0] memIData,
   output logic              memIReady,
   output logic              memIErr,
   input  logic              reqD,
   input  logic [ADDR_W-1:0] memDAddr,
   input  logic [DATA_W-1:0] memDData,
   input  logic              wr,
   input  logic [1:0]        size,
   output logic [DATA_W-1:0] memDRdata,
   output logic              memDReady,
   output logic              memDErr,
   output logic              busy,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memWr,
   output logic [3:0]        memBe,
   output logic [DATA_W-1:0] memDataOut,
   input  logic [DATA_W-1:0] memDataIn,
   input  logic              memAck
);

   localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic {PORT_I, PORT_D} port_t;

   state_t            state;
   port_t             last_grant;
   port_t             owner;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [1:0]        d_off;
   logic [1:0]        d_size;
   logic              d_wr;

   logic              pick_i;
   logic              pick_d;
   logic              d_bad;
   logic [3:0]        d_be;
   logic [DATA_W-1:0] d_wdata;
   logic              tmo_last;
   logic              unused_ibits;

   assign unused_ibits = ^memIAddr[1:0];
   assign busy         = (state != IDLE);
   assign tmo_last     = (tmo_cnt == CNT_W'(TMO_CYC - 1));

   // Tie goes to the port that did not win last time.
   always_comb begin
      pick_d  = reqD && (!reqI || last_grant == PORT_I);
      pick_i  = reqI && !pick_d;
      d_bad   = 1'b0;
      d_be    = 4'b1111;
      d_wdata = memDData;
      case (size)
         2'b00: begin
            d_be    = 4'b0001 << memDAddr[1:0];
            d_wdata = {4{memDData[7:0]}};
         end
         2'b01: begin
            d_bad   = memDAddr[0];
            d_be    = 4'b0011 << memDAddr[1:0];
            d_wdata = {2{memDData[15:0]}};
         end
         2'b10:   d_bad = (memDAddr[1:0] != 2'b00);
         default: d_bad = 1'b1;
      endcase
   end

   function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [1:0] sz);
      logic [DATA_W-1:0] sh;
      sh = word >> {off, 3'b000};
      case (sz)
         2'b00:   align_load = {{(DATA_W-8){1'b0}}, sh[7:0]};
         2'b01:   align_load = {{(DATA_W-16){1'b0}}, sh[15:0]};
         default: align_load = sh;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= PORT_D;
         owner      <= PORT_I;
         tmo_cnt    <= '0;
         d_off      <= '0;
         d_size     <= '0;
         d_wr       <= 1'b0;
         memReq     <= 1'b0;
         memAddr    <= '0;
         memWr      <= 1'b0;
         memBe      <= '0;
         memDataOut <= '0;
         memIData   <= '0;
         memIReady  <= 1'b0;
         memIErr    <= 1'b0;
         memDRdata  <= '0;
         memDReady  <= 1'b0;
         memDErr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (pick_i) begin
                  owner      <= PORT_I;
                  last_grant <= PORT_I;
                  memAddr    <= {memIAddr[ADDR_W-1:2], 2'b00};
                  memWr      <= 1'b0;
                  memBe      <= 4'b1111;
                  memDataOut <= '0;
                  memReq     <= 1'b1;
                  state      <= WAIT;
               end else if (pick_d) begin
                  owner      <= PORT_D;
                  last_grant <= PORT_D;
                  d_off      <= memDAddr[1:0];
                  d_size     <= size;
                  d_wr       <= wr;
                  // Rejected accesses never touch memory; answer straight from IDLE.
                  if (d_bad) begin
                     memDReady <= 1'b1;
                     memDErr   <= 1'b1;
                     memDRdata <= '0;
                     state     <= RESP;
                  end else begin
                     memAddr    <= {memDAddr[ADDR_W-1:2], 2'b00};
                     memWr      <= wr;
                     memBe      <= d_be;
                     memDataOut <= d_wdata;
                     memReq     <= 1'b1;
                     state      <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (memAck || tmo_last) begin
                  memReq <= 1'b0;
                  state  <= RESP;
                  if (owner == PORT_I) begin
                     memIReady <= 1'b1;
                     memIErr   <= !memAck;
                     memIData  <= memAck ? memDataIn : '0;
                  end else begin
                     memDReady <= 1'b1;
                     memDErr   <= !memAck;
                     memDRdata <= (memAck && !d_wr) ? align_load(memDataIn, d_off, d_size) : '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               memIReady <= 1'b0;
               memIErr   <= 1'b0;
               memIData  <= '0;
               memDReady <= 1'b0;
               memDErr   <= 1'b0;
               memDRdata <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model is
// compared against the DUT every cycle, plus literal checks on key results.
module tb_mem_port_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqI;
   logic [31:0] memIAddr;
   logic [31:0] memIData;
   logic        memIReady;
   logic        memIErr;
   logic        reqD;
   logic [31:0] memDAddr;
   logic [31:0] memDData;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] memDRdata;
   logic        memDReady;
   logic        memDErr;
   logic        busy;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memWr;
   logic [3:0]  memBe;
   logic [31:0] memDataOut;
   logic [31:0] memDataIn;
   logic        memAck;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
      .clk(clk), .reset(reset),
      .reqI(reqI), .memIAddr(memIAddr), .memIData(memIData),
      .memIReady(memIReady), .memIErr(memIErr),
      .reqD(reqD), .memDAddr(memDAddr), .memDData(memDData), .wr(wr), .size(size),
      .memDRdata(memDRdata), .memDReady(memDReady), .memDErr(memDErr),
      .busy(busy), .memReq(memReq), .memAddr(memAddr), .memWr(memWr),
      .memBe(memBe), .memDataOut(memDataOut), .memDataIn(memDataIn), .memAck(memAck)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   bit          m_tx, m_resp, m_last_d, m_owner_d, m_wr;
   int          m_waits, m_off, m_nb;
   logic        e_busy, e_memReq, e_memWr, e_IReady, e_IErr, e_DReady, e_DErr;
   logic [31:0] e_memAddr, e_memDataOut, e_IData, e_DRdata;
   logic [3:0]  e_memBe;

   function automatic logic [31:0] extract(input logic [31:0] w, input int off, input int nb);
      logic [31:0] r;
      r = 0;
      for (int i = 0; i < nb; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
      return r;
   endfunction

   task automatic clear_resp();
      e_IReady = 0; e_IErr = 0; e_IData = 0;
      e_DReady = 0; e_DErr = 0; e_DRdata = 0;
   endtask

   task automatic model_step();
      bit take_i, take_d, err;
      int off, nb;
      if (reset) begin
         m_tx = 0; m_resp = 0; m_last_d = 1; m_waits = 0;
         e_memReq = 0; e_memAddr = 0; e_memWr = 0; e_memBe = 0; e_memDataOut = 0;
         clear_resp();
      end else if (m_resp) begin
         m_resp = 0;
         clear_resp();
      end else if (m_tx) begin
         m_waits++;
         if (memAck || m_waits == TMO) begin
            err = !memAck;
            m_tx = 0; m_resp = 1; e_memReq = 0;
            if (!m_owner_d) begin
               e_IReady = 1; e_IErr = err; e_IData = err ? 0 : memDataIn;
            end else begin
               e_DReady = 1; e_DErr = err;
               e_DRdata = (err || m_wr) ? 0 : extract(memDataIn, m_off, m_nb);
            end
         end
      end else begin
         take_i = reqI && (!reqD || m_last_d);
         take_d = reqD && !take_i;
         m_waits = 0;
         if (take_i) begin
            m_last_d = 0; m_owner_d = 0; m_tx = 1;
            e_memReq = 1; e_memAddr = memIAddr & 32'hFFFF_FFFC; e_memWr = 0; e_memBe = 4'hF;
         end else if (take_d) begin
            m_last_d = 1; m_owner_d = 1;
            off = int'(memDAddr % 4);
            nb  = (size == 2'b11) ? 0 : (1 << size);
            if (nb == 0 || (off % nb) != 0) begin
               m_resp = 1; e_DReady = 1; e_DErr = 1; e_DRdata = 0;
            end else begin
               m_tx = 1; m_off = off; m_nb = nb; m_wr = wr;
               e_memReq = 1; e_memAddr = memDAddr & 32'hFFFF_FFFC; e_memWr = wr;
               for (int l = 0; l < 4; l++) begin
                  e_memBe[l] = (l >= off) && (l < off + nb);
                  e_memDataOut[8*l +: 8] = memDData[8*(l % nb) +: 8];
               end
            end
         end
      end
      e_busy = m_tx || m_resp;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("busy", busy, e_busy);
         chk("memReq", memReq, e_memReq);
         chk("memIReady", memIReady, e_IReady);
         chk("memIErr", memIErr, e_IErr);
         chk("memDReady", memDReady, e_DReady);
         chk("memDErr", memDErr, e_DErr);
         if (e_memReq) begin
            chk("memAddr", memAddr, e_memAddr);
            chk("memWr", memWr, e_memWr);
            chk("memBe", memBe, e_memBe);
            if (e_memWr) chk("memDataOut", memDataOut, e_memDataOut);
         end
         if (e_IReady && !e_IErr) chk("memIData", memIData, e_IData);
         if (e_DReady) chk("memDRdata", memDRdata, e_DRdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_req(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (memReq) begin ok = 1; break; end
      end
      if (!ok) bound_fail(name);
   endtask

   // Ack during the n-th cycle memReq is high (called in WAIT cycle 1).
   task automatic ack_in(input int n, input logic [31:0] data);
      cyc(n - 1);
      memAck = 1; memDataIn = data;
      cyc(1);
      memAck = 0; memDataIn = 32'h0BAD_0BAD;
   endtask

   task automatic set_d(input logic [31:0] a, input logic [1:0] s, input logic w, input logic [31:0] d);
      reqD = 1; memDAddr = a; size = s; wr = w; memDData = d;
   endtask

   initial begin
      int n;
      logic [31:0] alt_addr [4];
      reset = 1; reqI = 0; memIAddr = 0; reqD = 0; memDAddr = 0; memDData = 0;
      wr = 0; size = 0; memDataIn = 0; memAck = 0;
      cyc(2);
      chk_en = 1;
      chk("rst_memReq", memReq, 0);   chk("rst_busy", busy, 0);
      chk("rst_memAddr", memAddr, 0); chk("rst_memBe", memBe, 0);
      chk("rst_memWr", memWr, 0);     chk("rst_memDataOut", memDataOut, 0);
      chk("rst_IReady", memIReady, 0); chk("rst_IData", memIData, 0);
      chk("rst_DReady", memDReady, 0); chk("rst_DRdata", memDRdata, 0);
      chk("rst_IErr", memIErr, 0);     chk("rst_DErr", memDErr, 0);
      reset = 0;
      cyc(1);

      // Fetch 0x103, ack three cycles after memReq.
      reqI = 1; memIAddr = 32'h103;
      wait_req("fetch_req");
      chk("fetch_addr", memAddr, 32'h100);
      chk("fetch_be", memBe, 4'hF);
      chk("fetch_wr", memWr, 0);
      ack_in(4, 32'hDEADBEEF);
      chk("fetch_ready", memIReady, 1);
      chk("fetch_data", memIData, 32'hDEADBEEF);
      reqI = 0;
      cyc(2);

      // Store byte to 0x203.
      set_d(32'h203, 2'b00, 1, 32'hA5);
      wait_req("sb_req");
      chk("sb_addr", memAddr, 32'h200);
      chk("sb_be", memBe, 4'b1000);
      chk("sb_wdata", memDataOut, 32'hA5A5A5A5);
      chk("sb_wr", memWr, 1);
      ack_in(2, 32'h0);
      chk("sb_ready", memDReady, 1);
      reqD = 0;
      cyc(1);

      // Load half from 0x102.
      set_d(32'h102, 2'b01, 0, 0);
      wait_req("lh_req");
      chk("lh_be", memBe, 4'b1100);
      ack_in(1, 32'h12345678);
      chk("lh_rdata", memDRdata, 32'h00001234);
      reqD = 0;
      cyc(1);

      // Load byte 0x13, store half 0x206.
      set_d(32'h13, 2'b00, 0, 0);
      wait_req("lb_req");
      ack_in(3, 32'h12345678);
      chk("lb_rdata", memDRdata, 32'h12);
      set_d(32'h206, 2'b01, 1, 32'h1234BEEF);
      wait_req("sh_req");
      chk("sh_wdata", memDataOut, 32'hBEEFBEEF);
      ack_in(2, 32'h0);
      reqD = 0;
      cyc(1);

      // Misaligned half, misaligned word, illegal size: immediate error.
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: set_d(32'h101, 2'b01, 0, 0);
            1: set_d(32'h202, 2'b10, 1, 0);
            default: set_d(32'h200, 2'b11, 0, 0);
         endcase
         n = 0;
         while (!memDReady && n < 10) begin cyc(1); n++; end
         chk("bad_latency", n, 1);
         chk("bad_err", memDErr, 1);
         reqD = 0;
         cyc(1);
      end

      // Timeout with no ack.
      reqI = 1; memIAddr = 32'h40;
      wait_req("tmo_req");
      n = 0;
      while (memReq && n < 20) begin cyc(1); n++; end
      chk("tmo_len", n, TMO);
      chk("tmo_ready", memIReady, 1);
      chk("tmo_err", memIErr, 1);
      reqI = 0;
      cyc(1);

      // Ack in the expiry cycle wins.
      set_d(32'h10, 2'b10, 0, 0);
      wait_req("late_req");
      ack_in(TMO, 32'hCAFEF00D);
      chk("late_ready", memDReady, 1);
      chk("late_err", memDErr, 0);
      chk("late_data", memDRdata, 32'hCAFEF00D);
      reqD = 0;
      cyc(1);

      // memAck while idle is ignored.
      memAck = 1; memDataIn = 32'h77;
      cyc(1);
      memAck = 0;
      cyc(1);
      chk("stray_ack_busy", busy, 0);

      // Both requesting from reset: strict alternation starting with I.
      reset = 1; cyc(1);
      reqI = 1; memIAddr = 32'h500;
      set_d(32'h600, 2'b10, 0, 0);
      cyc(1);
      reset = 0;
      alt_addr[0] = 32'h500; alt_addr[1] = 32'h600;
      alt_addr[2] = 32'h500; alt_addr[3] = 32'h600;
      for (int k = 0; k < 4; k++) begin
         wait_req("alt_req");
         chk("alt_addr", memAddr, alt_addr[k]);
         ack_in(2, 32'h1000 + k);
         chk("alt_ready", {memIReady, memDReady}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      reqI = 0; reqD = 0;
      cyc(2);

      // Reset during WAIT, then a normal transaction.
      reqI = 1; memIAddr = 32'h700;
      wait_req("rst_wait_req");
      cyc(1);
      reset = 1;
      cyc(1);
      chk("rstw_memReq", memReq, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_ready", memIReady, 0);
      reset = 0;
      wait_req("post_rst_req");
      ack_in(2, 32'h55AA55AA);
      chk("post_rst_data", memIData, 32'h55AA55AA);
      reqI = 0;
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
